config_uart_tx: RTL and testbench

- Byte-stream UART transmitter (8N1, LSB first) that drives the eFPGA_top `Rx` configuration pin.
- Lets benches and bring-up logic load bitstreams serially, as the alternative to the `SelfWriteData`/`SelfWriteStrobe` parallel path.
- Accepts bytes on a valid/ready handshake into a small FIFO and serialises them back-to-back.
- Sits between a bitstream byte source and the fabric's UART configuration receiver.

---
 rtl/config_uart_tx.sv | 157 +++++++++++++++
 tb/tb_config_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_uart_tx.sv
// 8N1 LSB-first UART transmitter feeding the fabric configuration Rx pin.
// Bytes enter through a valid/ready FIFO and leave back-to-back with no idle gap.
module config_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   Tx,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   s_ready_q, s_ready_d;
  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic [COUNT_WIDTH-1:0] frames_q, frames_d;

  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       baud_last;
  logic [7:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign baud_last  = (baud_q == BAUD_LAST);
  assign push       = s_valid & s_ready_q;

  // Storage is not reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    frames_d  = frames_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        if (baud_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        if (baud_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // Next bit is already sitting at shift_q[1]; drive it from the same edge.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

      STOP: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        if (baud_last) begin
          frames_d = frames_q + COUNT_WIDTH'(1);
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    // Full when the pointers differ only in the wrap bit.
    s_ready_d = ((wr_ptr_d ^ rd_ptr_d) != {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b1;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      frames_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      frames_q  <= frames_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign Tx          = tx_q;
  assign busy        = (state_q != IDLE) | ~fifo_empty;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_config_uart_tx.sv
// Scoreboard bench for config_uart_tx: three instances (4, 2 and 7 clocks per bit)
// share one driver and one reference receiver, selected by sel.
module tb_config_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic [2:0]  s_valid_v;
  logic [2:0]  rdy_v;
  logic [2:0]  tx_v;
  logic [2:0]  busy_v;
  logic [15:0] fs_v [3];

  logic [1:0]  sel;
  int          cpb;
  logic        tx_sel, rdy_sel, busy_sel;
  logic [15:0] fs_sel;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  int         starts_q [$];
  int         exp_frames [3];

  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;
  bit         cnt_pending = 1'b0;
  int         pos;
  int         bad;
  logic [7:0] cur;
  logic [7:0] dec;

  always #5 clk = ~clk;

  assign tx_sel   = tx_v[sel];
  assign rdy_sel  = rdy_v[sel];
  assign busy_sel = busy_v[sel];
  assign fs_sel   = fs_v[sel];

  config_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .COUNT_WIDTH(16)) u_cpb4 (
    .CLK(clk), .resetn(rst_n), .s_data(s_data), .s_valid(s_valid_v[0]),
    .s_ready(rdy_v[0]), .Tx(tx_v[0]), .busy(busy_v[0]), .frames_sent(fs_v[0]));

  config_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8), .COUNT_WIDTH(16)) u_cpb2 (
    .CLK(clk), .resetn(rst_n), .s_data(s_data), .s_valid(s_valid_v[1]),
    .s_ready(rdy_v[1]), .Tx(tx_v[1]), .busy(busy_v[1]), .frames_sent(fs_v[1]));

  config_uart_tx #(.CLKS_PER_BIT(7), .FIFO_DEPTH(8), .COUNT_WIDTH(16)) u_cpb7 (
    .CLK(clk), .resetn(rst_n), .s_data(s_data), .s_valid(s_valid_v[2]),
    .s_ready(rdy_v[2]), .Tx(tx_v[2]), .busy(busy_v[2]), .frames_sent(fs_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference receiver: every cycle of a frame is compared with the expected line
  // level, and the byte is also decoded from mid-bit samples.
  always @(negedge clk) begin
    int   b;
    int   off;
    logic exp_bit;
    cyc++;
    if (!mon_en) begin
      in_frame    = 1'b0;
      cnt_pending = 1'b0;
    end else begin
      if (cnt_pending) begin
        check("frames_sent", fs_sel, exp_frames[sel]);
        if (exp_q.size() == 0 && s_valid_v == 3'b000)
          check("busy_fall", busy_sel, 1'b0);
        cnt_pending = 1'b0;
      end
      if (!in_frame && tx_sel == 1'b0) begin
        in_frame = 1'b1;
        pos      = 0;
        bad      = 0;
        dec      = 8'h00;
        starts_q.push_back(cyc);
        check("exp_avail", (exp_q.size() > 0), 1'b1);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      end
      if (in_frame) begin
        b   = pos / cpb;
        off = pos % cpb;
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
        if (tx_sel !== exp_bit) bad++;
        if (off == cpb / 2 && b >= 1 && b <= 8) dec[b-1] = tx_sel;
        pos++;
        if (pos == 10 * cpb) begin
          $display("frame dut_cpb=%0d byte=%02h expected=%02h bad_cycles=%0d", cpb, dec, cur, bad);
          check("frame_cycles", bad, 0);
          check("rx_byte", dec, cur);
          exp_frames[sel] = (exp_frames[sel] + 1) & 32'hFFFF;
          cnt_pending = 1'b1;
          in_frame    = 1'b0;
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    s_data    = b;
    s_valid_v = 3'b001 << sel;
    @(negedge clk);
    while (!rdy_sel && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", rdy_sel, 1'b1);
    if (rdy_sel) exp_q.push_back(b);
    @(posedge clk);
    #1;
    s_valid_v = 3'b000;
  endtask

  task automatic wait_idle(input int limit);
    int guard = 0;
    @(negedge clk);
    while ((busy_sel || in_frame || exp_q.size() != 0) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("idle_busy", busy_sel, 1'b0);
    check("idle_queue", exp_q.size(), 0);
    check("idle_tx", tx_sel, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic select_dut(input logic [1:0] s);
    sel = s;
    cpb = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 7;
  endtask

  initial begin
    int   n_acc;
    bit   dropped;
    bit   changed;
    logic [15:0] fs_prev;
    int   guard;
    int   gap;

    select_dut(2'd0);
    s_data    = 8'h00;
    s_valid_v = 3'b000;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) exp_frames[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", tx_sel, 1'b1);
    check("rst_ready", rdy_sel, 1'b1);
    check("rst_busy", busy_sel, 1'b0);
    check("rst_frames", fs_sel, 16'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single byte: line still high after the accept edge, low after the next.
    push_byte(8'hA5);
    @(negedge clk);
    check("lat_accept_edge", tx_sel, 1'b1);
    @(negedge clk);
    check("lat_pop_edge", tx_sel, 1'b0);
    @(posedge clk);
    #1;
    wait_idle(200);
    check("single_frames", fs_sel, 16'd1);

    // Back-to-back frames: start bits exactly one frame length apart.
    starts_q.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_idle(400);
    check("b2b_frames", fs_sel, 16'd4);
    check("b2b_count", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      check("b2b_gap0", starts_q[1] - starts_q[0], 40);
      check("b2b_gap1", starts_q[2] - starts_q[1], 40);
    end

    // Backpressure with s_valid held high.
    n_acc   = 0;
    dropped = 1'b0;
    guard   = 0;
    fs_prev = fs_sel;
    s_data  = 8'($urandom_range(0, 255));
    s_valid_v = 3'b001;
    while (n_acc < 12 && guard < 3000) begin
      @(negedge clk);
      guard++;
      changed = (fs_sel != fs_prev);
      fs_prev = fs_sel;
      if (!rdy_sel && !dropped) begin
        dropped = 1'b1;
        check("bp_accepts", n_acc, 9);
      end else if (dropped) begin
        check("bp_ready", rdy_sel, changed);
      end
      if (rdy_sel) begin
        exp_q.push_back(s_data);
        n_acc++;
        @(posedge clk);
        #1;
        s_data = 8'($urandom_range(0, 255));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    s_valid_v = 3'b000;
    check("bp_total", n_acc, 12);
    wait_idle(1000);
    check("bp_frames", fs_sel, 16'd16);

    // Random streams on the 2- and 7-clock instances.
    for (int d = 1; d <= 2; d++) begin
      select_dut(2'(d));
      for (int i = 0; i < 256; i++) begin
        push_byte(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 7) == 0) begin
          gap = $urandom_range(1, 3);
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      wait_idle(20 * cpb * 12);
      check("sweep_frames", fs_sel, 16'd256);
    end

    // Reset during data bit 3 of the first frame with four bytes queued.
    select_dut(2'd0);
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    repeat (15) @(negedge clk);
    check("pre_rst_tx", tx_sel, 1'b0);
    check("pre_rst_busy", busy_sel, 1'b1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_tx", tx_sel, 1'b1);
    check("mid_rst_busy", busy_sel, 1'b0);
    check("mid_rst_ready", rdy_sel, 1'b1);
    check("mid_rst_frames", fs_sel, 16'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_frames[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_tx", tx_sel, 1'b1);
    check("post_rst_busy", busy_sel, 1'b0);
    check("post_rst_frames", fs_sel, 16'd0);
    @(posedge clk);
    #1;
    push_byte(8'h5A);
    wait_idle(200);
    check("post_rst_one", fs_sel, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog simulation time limit reached got=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
